// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests for loads and
// stores, stalls the pipeline until the response arrives, flags misaligned
// accesses and holds the MEM/WB pipeline register.
//
// Request handshake: dmem_req_valid, dmem_we, dmem_addr and dmem_wdata are
// held stable from the first cycle valid is high until the cycle
// dmem_req_ready is also high, and the transfer happens on that rising edge.
// After acceptance the stage waits for exactly one dmem_rsp_valid pulse.
// dmem_rsp_valid is ignored at any other time.
module memory_access_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        regwriteM,
   input  logic        memwriteM,
   input  logic        isloadM,
   input  logic        memreadM,
   input  logic [4:0]  rdM,
   input  logic [31:0] aluresultM,
   input  logic [31:0] writedataM,
   input  logic [31:0] pcplus4M,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        regwriteW,
   output logic        isloadW,
   output logic [4:0]  rdW,
   output logic [31:0] aluresultW,
   output logic [31:0] readdataW,
   output logic [31:0] pcplus4W,
   output logic [31:0] resultW,
   output logic [1:0]  stateDbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state;
   state_t stateNext;

   logic memOp;
   logic misaligned;
   logic rspDone;

   assign memOp      = memreadM | memwriteM;
   assign misaligned = memOp & (aluresultM[1:0] != 2'b00);
   assign rspDone    = (state == WAIT) & dmem_rsp_valid;

   // A write wins over a read when both control bits are set.
   assign dmem_we    = memwriteM;
   assign dmem_addr  = aluresultM;
   assign dmem_wdata = writedataM;
   assign stateDbg   = state;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: issue from IDLE, hold in REQ until accepted, wait for the response.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (memOp && !misaligned) begin
               stateNext = dmem_req_ready ? WAIT : REQ;
            end
         end
         REQ: begin
            if (dmem_req_ready) begin
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (dmem_rsp_valid) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Output logic: request valid, stall and misalign flag, all forced low during reset.
   always_comb begin
      dmem_req_valid = 1'b0;
      stall_o        = 1'b0;
      misalign_o     = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               dmem_req_valid = memOp & ~misaligned;
               stall_o        = memOp & ~misaligned;
               misalign_o     = misaligned;
            end
            REQ: begin
               dmem_req_valid = 1'b1;
               stall_o        = 1'b1;
            end
            WAIT: begin
               // The response cycle releases the stall so the instruction retires on this edge.
               stall_o = ~dmem_rsp_valid;
            end
            default: begin
               dmem_req_valid = 1'b0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while stalled, otherwise load the instruction (write-back suppressed if misaligned).
   always_ff @(posedge clk) begin
      if (rst) begin
         regwriteW  <= 1'b0;
         isloadW    <= 1'b0;
         rdW        <= 5'd0;
         aluresultW <= 32'd0;
         readdataW  <= 32'd0;
         pcplus4W   <= 32'd0;
      end else if (stall_o) begin
         regwriteW <= 1'b0;
         isloadW   <= 1'b0;
         rdW       <= 5'd0;
      end else begin
         regwriteW  <= regwriteM & ~misaligned;
         isloadW    <= isloadM;
         rdW        <= rdM;
         aluresultW <= aluresultM;
         pcplus4W   <= pcplus4M;
         readdataW  <= (rspDone && !memwriteM) ? dmem_rdata : 32'd0;
      end
   end

   // Write-back result selection.
   assign resultW = isloadW ? readdataW : aluresultW;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage: inputs are driven 1 time unit
// after the rising edge and outputs are sampled on the falling edge.
module tb_memory_access_stage;

   logic        clk;
   logic        rst;
   logic        regwriteM;
   logic        memwriteM;
   logic        isloadM;
   logic        memreadM;
   logic [4:0]  rdM;
   logic [31:0] aluresultM;
   logic [31:0] writedataM;
   logic [31:0] pcplus4M;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        stall_o;
   logic        misalign_o;
   logic        regwriteW;
   logic        isloadW;
   logic [4:0]  rdW;
   logic [31:0] aluresultW;
   logic [31:0] readdataW;
   logic [31:0] pcplus4W;
   logic [31:0] resultW;
   logic [1:0]  stateDbg;

   int checks = 0;
   int errors = 0;

   // scoreboard of expected load data, in issue order
   logic [31:0] exp_q[$];

   // windowed monitors for the back-to-back load test
   logic count_en = 1'b0;
   int   req_count = 0;
   int   wr_count  = 0;

   memory_access_stage dut (
      .clk            (clk),
      .rst            (rst),
      .regwriteM      (regwriteM),
      .memwriteM      (memwriteM),
      .isloadM        (isloadM),
      .memreadM       (memreadM),
      .rdM            (rdM),
      .aluresultM     (aluresultM),
      .writedataM     (writedataM),
      .pcplus4M       (pcplus4M),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rdata     (dmem_rdata),
      .stall_o        (stall_o),
      .misalign_o     (misalign_o),
      .regwriteW      (regwriteW),
      .isloadW        (isloadW),
      .rdW            (rdW),
      .aluresultW     (aluresultW),
      .readdataW      (readdataW),
      .pcplus4W       (pcplus4W),
      .resultW        (resultW),
      .stateDbg       (stateDbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // accepted requests and retired register writes inside the window
   always @(posedge clk) begin
      if (count_en && dmem_req_valid && dmem_req_ready) req_count++;
   end
   always @(negedge clk) begin
      if (count_en && regwriteW) wr_count++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_instr(input logic rw, input logic mw, input logic il, input logic mr,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] wd, input logic [31:0] pc);
      regwriteM  = rw;
      memwriteM  = mw;
      isloadM    = il;
      memreadM   = mr;
      rdM        = rd;
      aluresultM = alu;
      writedataM = wd;
      pcplus4M   = pc;
   endtask

   task automatic drive_nop();
      drive_instr(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic drive_mem(input logic ready, input logic rsp, input logic [31:0] rdata);
      dmem_req_ready = ready;
      dmem_rsp_valid = rsp;
      dmem_rdata     = rdata;
   endtask

   initial begin
      // reset, with a load presented to confirm outputs stay quiet
      rst = 1'b1;
      drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h8, 32'd0, 32'h4);
      drive_mem(1'b1, 1'b0, 32'd0);
      next_cycle();
      sample();
      check("rst_req_valid", dmem_req_valid, 1'b0);
      check("rst_stall", stall_o, 1'b0);
      check("rst_misalign", misalign_o, 1'b0);
      check("rst_regwriteW", regwriteW, 1'b0);
      check("rst_resultW", resultW, 32'd0);
      check("rst_state", stateDbg, 2'd0);
      next_cycle();
      rst = 1'b0;
      drive_nop();
      drive_mem(1'b0, 1'b0, 32'd0);

      // ALU op: retires next edge with no stall
      next_cycle();
      drive_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h10, 32'h0, 32'h44);
      sample();
      check("alu_stall", stall_o, 1'b0);
      check("alu_req_valid", dmem_req_valid, 1'b0);

      // load 0x100, accepted at once, response next cycle
      next_cycle();
      drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 32'h48);
      drive_mem(1'b1, 1'b0, 32'd0);
      sample();
      check("alu_regwriteW", regwriteW, 1'b1);
      check("alu_rdW", rdW, 5'd5);
      check("alu_resultW", resultW, 32'h10);
      check("alu_pcplus4W", pcplus4W, 32'h44);
      check("ld_req_valid", dmem_req_valid, 1'b1);
      check("ld_we", dmem_we, 1'b0);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_stall_issue", stall_o, 1'b1);
      next_cycle();
      drive_mem(1'b0, 1'b1, 32'hDEADBEEF);
      sample();
      check("ld_state_wait", stateDbg, 2'd2);
      check("ld_stall_rsp", stall_o, 1'b0);
      check("ld_req_valid_rsp", dmem_req_valid, 1'b0);
      check("ld_bubble_regwriteW", regwriteW, 1'b0);
      check("ld_bubble_rdW", rdW, 5'd0);
      check("ld_bubble_alu_kept", aluresultW, 32'h10);

      // store 0x204 immediately after; ready held low 3 cycles, spurious response in REQ
      next_cycle();
      drive_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h204, 32'h55, 32'h4C);
      drive_mem(1'b0, 1'b0, 32'd0);
      sample();
      check("ld_isloadW", isloadW, 1'b1);
      check("ld_regwriteW", regwriteW, 1'b1);
      check("ld_rdW", rdW, 5'd7);
      check("ld_resultW", resultW, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            next_cycle();
            drive_mem(i == 3, i == 1, 32'hBAD0BAD0);
            sample();
            check("st_bubble_regwriteW", regwriteW, 1'b0);
            check("st_state_req", stateDbg, 2'd1);
         end
         check("st_req_valid", dmem_req_valid, 1'b1);
         check("st_we", dmem_we, 1'b1);
         check("st_addr", dmem_addr, 32'h204);
         check("st_wdata", dmem_wdata, 32'h55);
         check("st_stall", stall_o, 1'b1);
      end
      next_cycle();
      drive_mem(1'b0, 1'b0, 32'd0);
      sample();
      check("st_wait_req_valid", dmem_req_valid, 1'b0);
      check("st_wait_stall", stall_o, 1'b1);
      next_cycle();
      drive_mem(1'b0, 1'b1, 32'h11112222);
      sample();
      check("st_rsp_stall", stall_o, 1'b0);

      // misaligned load 0x102: flag only, no request, no stall
      next_cycle();
      drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h102, 32'h0, 32'h54);
      drive_mem(1'b1, 1'b0, 32'd0);
      sample();
      check("st_regwriteW", regwriteW, 1'b0);
      check("st_readdataW", readdataW, 32'd0);
      check("st_resultW", resultW, 32'h204);
      check("mis_pulse", misalign_o, 1'b1);
      check("mis_req_valid", dmem_req_valid, 1'b0);
      check("mis_stall", stall_o, 1'b0);
      next_cycle();
      drive_nop();
      sample();
      check("mis_pulse_end", misalign_o, 1'b0);
      check("mis_regwriteW", regwriteW, 1'b0);
      check("mis_rdW", rdW, 5'd9);
      check("mis_aluresultW", aluresultW, 32'h102);
      check("mis_state", stateDbg, 2'd0);

      // reset while waiting, then a late response
      next_cycle();
      drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h300, 32'h0, 32'h58);
      sample();
      check("rw_req_valid", dmem_req_valid, 1'b1);
      next_cycle();
      drive_mem(1'b0, 1'b0, 32'd0);
      rst = 1'b1;
      sample();
      check("rw_state_wait", stateDbg, 2'd2);
      check("rw_stall_in_rst", stall_o, 1'b0);
      next_cycle();
      rst = 1'b0;
      drive_nop();
      drive_mem(1'b0, 1'b1, 32'h12345678);
      sample();
      check("rw_state_idle", stateDbg, 2'd0);
      check("rw_aluresultW", aluresultW, 32'd0);
      check("rw_pcplus4W", pcplus4W, 32'd0);
      check("rw_stall_late", stall_o, 1'b0);
      next_cycle();
      drive_mem(1'b0, 1'b0, 32'd0);
      sample();
      check("rw_late_readdataW", readdataW, 32'd0);
      check("rw_late_state", stateDbg, 2'd0);

      // two back-to-back loads
      next_cycle();
      count_en = 1'b1;
      drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h400, 32'h0, 32'h60);
      drive_mem(1'b1, 1'b0, 32'd0);
      sample();
      check("b2b_a_addr", dmem_addr, 32'h400);
      next_cycle();
      drive_mem(1'b0, 1'b1, 32'hA5A50001);
      exp_q.push_back(32'hA5A50001);
      sample();
      check("b2b_a_no_reissue", dmem_req_valid, 1'b0);
      next_cycle();
      drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h404, 32'h0, 32'h64);
      drive_mem(1'b1, 1'b0, 32'd0);
      sample();
      check("b2b_b_req_valid", dmem_req_valid, 1'b1);
      check("b2b_b_addr", dmem_addr, 32'h404);
      check("b2b_a_rdW", rdW, 5'd3);
      check("b2b_a_readdataW", readdataW, exp_q.pop_front());
      next_cycle();
      drive_mem(1'b0, 1'b1, 32'h5A5A0002);
      exp_q.push_back(32'h5A5A0002);
      sample();
      check("b2b_b_bubble", regwriteW, 1'b0);
      next_cycle();
      drive_nop();
      drive_mem(1'b0, 1'b0, 32'd0);
      sample();
      check("b2b_b_rdW", rdW, 5'd4);
      check("b2b_b_readdataW", readdataW, exp_q.pop_front());
      next_cycle();
      count_en = 1'b0;
      check("b2b_req_count", req_count, 32'd2);
      check("b2b_wr_count", wr_count, 32'd2);
      check("b2b_queue_empty", exp_q.size(), 32'd0);

      // read and write both set: write wins, no read data captured
      drive_instr(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h500, 32'h77, 32'h68);
      drive_mem(1'b1, 1'b0, 32'd0);
      sample();
      check("rw_both_we", dmem_we, 1'b1);
      check("rw_both_req_valid", dmem_req_valid, 1'b1);
      next_cycle();
      drive_mem(1'b0, 1'b1, 32'hFFFFFFFF);
      sample();
      check("rw_both_stall", stall_o, 1'b0);
      next_cycle();
      drive_nop();
      drive_mem(1'b0, 1'b0, 32'd0);
      sample();
      check("rw_both_readdataW", readdataW, 32'd0);
      check("rw_both_aluresultW", aluresultW, 32'h500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
